// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI counter-frame slave.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_HIGH,
        RX_LOW,
        FULL,
        OVERRUN
    } rx_state_t;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 14;
    localparam int PAD_W      = 2;
    localparam int BYTE_W     = 8;

    localparam logic [7:0] DEFAULT_ID_BYTE = 8'hA5;
    localparam logic [4:0] BIT_CNT_MAX     = 5'd17;
    localparam logic [4:0] BIT_CNT_BYTE    = 5'd8;

    // Bit counter advance, saturating so overlong frames stay recognisable.
    function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
        return (cnt >= BIT_CNT_MAX) ? cnt : cnt + 5'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall strobes for one async input.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;
    // Edges are suppressed until the chain holds only real samples, so the
    // reset level never produces a phantom edge.
    logic [STAGES:0]   vld_pipe;

    assign level = sync[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= {STAGES{RESET_VAL}};
            prev     <= RESET_VAL;
            vld_pipe <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync     <= {sync[STAGES-2:0], din};
            prev     <= sync[STAGES-1];
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            rise     <= vld_pipe[STAGES] &  sync[STAGES-1] & ~prev;
            fall     <= vld_pipe[STAGES] & ~sync[STAGES-1] &  prev;
        end
    end

endmodule

// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave receiving {pad, cnt[13:8]}, cnt[7:0] frames; answers ID then sequence byte.
module spi_counter_slave_rx
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_BYTE     = DEFAULT_ID_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic [CNT_W-1:0]  o_counter,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic [BYTE_W-1:0] o_frame_cnt
);

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;
    logic mosi_lvl;
    logic [1:0] unused_levels;
    logic [1:0] unused_mosi_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (unused_levels[0]),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ss),
        .level (unused_levels[1]),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .level (mosi_lvl),
        .rise  (unused_mosi_edges[0]),
        .fall  (unused_mosi_edges[1])
    );

    rx_state_t             state;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [BYTE_W-1:0]     tx_shift;
    // Set by the first ss fall after reset; an ss rise seen before that is
    // the tail of a frame aborted by reset and is dropped silently.
    logic                  armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            armed       <= 1'b0;
            miso        <= 1'b0;
            o_counter   <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;

            if (ss_rise) begin
                // End of frame wins over any coincident sclk edge.
                state <= IDLE;
                miso  <= 1'b0;
                if (state == FULL && rx_shift[FRAME_BITS-1 -: PAD_W] == '0) begin
                    o_counter   <= rx_shift[CNT_W-1:0];
                    o_valid     <= 1'b1;
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                end else if (armed) begin
                    o_frame_err <= 1'b1;
                end
            end else if (ss_fall) begin
                state    <= RX_HIGH;
                armed    <= 1'b1;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= ID_BYTE;
                miso     <= ID_BYTE[BYTE_W-1];
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_lvl};
                    bit_cnt  <= bit_cnt_inc(bit_cnt);
                    case (state)
                        RX_HIGH: if (bit_cnt == BIT_CNT_BYTE - 5'd1) state <= RX_LOW;
                        RX_LOW:  if (bit_cnt == 5'd15)               state <= FULL;
                        FULL:    state <= OVERRUN;
                        default: ;
                    endcase
                end else if (sclk_fall) begin
                    // Second byte reports how many frames were accepted before this one.
                    if (bit_cnt == BIT_CNT_BYTE) begin
                        tx_shift <= o_frame_cnt;
                        miso     <= o_frame_cnt[BYTE_W-1];
                    end else begin
                        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                        miso     <= tx_shift[BYTE_W-2];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Bench for spi_counter_slave_rx: frame-level model plus per-cycle output compare.
module tb_spi_counter_slave_rx;

    localparam int         S    = 2;
    localparam logic [7:0] ID   = 8'hA5;
    localparam int         HALF = 5;

    logic        clk = 1'b0;
    logic        reset, sclk, mosi, ss;
    logic        miso;
    logic [13:0] o_counter;
    logic        o_valid, o_frame_err;
    logic [7:0]  o_frame_cnt;

    spi_counter_slave_rx #(.SYNC_STAGES(S), .ID_BYTE(ID)) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .mosi        (mosi),
        .ss          (ss),
        .miso        (miso),
        .o_counter   (o_counter),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        bit          ok;
        logic [13:0] val;
    } ev_t;
    ev_t pend[$];

    int          m_counter = 0;
    int          m_cnt     = 0;
    int          checks    = 0;
    int          errors    = 0;
    int          n_valid   = 0;
    int          n_err     = 0;
    logic [31:0] cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A frame that ends with ss sampled high at edge E resolves after edge E+S+1.
    always @(negedge clk) begin
        bit ev_now, ev_ok;
        if (!reset) begin
            ev_now = 1'b0;
            ev_ok  = 1'b0;
            if (pend.size() > 0 && pend[0].at == cyc) begin
                ev_now = 1'b1;
                ev_ok  = pend[0].ok;
                if (ev_ok) begin
                    m_counter = int'(pend[0].val);
                    m_cnt     = (m_cnt + 1) % 256;
                end
                void'(pend.pop_front());
            end
            if (o_valid)     n_valid++;
            if (o_frame_err) n_err++;
            chk("o_valid",     {31'd0, o_valid},     {31'd0, ev_now & ev_ok});
            chk("o_frame_err", {31'd0, o_frame_err}, {31'd0, ev_now & ~ev_ok});
            chk("o_counter",   {18'd0, o_counter},   m_counter);
            chk("o_frame_cnt", {24'd0, o_frame_cnt}, m_cnt);
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        m_counter = 0;
        m_cnt     = 0;
        pend.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        cap  = {cap[30:0], miso};
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Sends n bits MSB first; the model decides accept/reject from the frame rules.
    task automatic send_frame(input logic [31:0] bits, input int n, output logic [15:0] miso_bytes);
        int   seq_before;
        bit   ok;
        seq_before = m_cnt;
        cap = '0;
        ss  = 1'b0;
        for (int i = n - 1; i >= 0; i--) clock_bit(bits[i]);
        repeat (2) @(negedge clk);
        ss = 1'b1;
        ok = (n == 16) && (bits[15:14] == 2'b00);
        pend.push_back('{cyc + S + 2, ok, bits[13:0]});
        miso_bytes = cap[n-1 -: 16];
        if (n == 16) chk("miso_bytes", {16'd0, miso_bytes}, {16'd0, ID, 8'(seq_before)});
        repeat (8) @(negedge clk);
        chk("miso_idle", {31'd0, miso}, 32'd0);
    endtask

    logic [15:0] mb;
    int          v0, e0;

    initial begin
        reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        chk("rst_counter", {18'd0, o_counter}, 32'd0);
        chk("rst_cnt",     {24'd0, o_frame_cnt}, 32'd0);
        chk("rst_valid",   {31'd0, o_valid}, 32'd0);
        chk("rst_err",     {31'd0, o_frame_err}, 32'd0);
        chk("rst_miso",    {31'd0, miso}, 32'd0);

        send_frame(32'h002A, 16, mb);
        chk("t1_counter", {18'd0, o_counter}, 32'd42);
        chk("t1_cnt",     {24'd0, o_frame_cnt}, 32'd1);
        chk("t1_miso",    {16'd0, mb}, 32'hA500);

        do_reset();
        send_frame(32'h3FFF, 16, mb);
        chk("t2a_counter", {18'd0, o_counter}, 32'd16383);
        send_frame(32'h0000, 16, mb);
        chk("t2b_counter", {18'd0, o_counter}, 32'd0);
        chk("t2b_miso",    {16'd0, mb}, 32'hA501);

        send_frame(32'h1234, 16, mb);
        v0 = n_valid; e0 = n_err;
        send_frame(32'h4000, 16, mb);
        chk("pad_counter", {18'd0, o_counter}, 32'h1234);
        chk("pad_cnt",     {24'd0, o_frame_cnt}, 32'd3);
        chk("pad_errs",    n_err - e0, 32'd1);
        chk("pad_valids",  n_valid - v0, 32'd0);

        v0 = n_valid; e0 = n_err;
        send_frame(32'h0ABC, 12, mb);
        send_frame(32'h00055, 17, mb);
        chk("len_errs",   n_err - e0, 32'd2);
        chk("len_valids", n_valid - v0, 32'd0);
        chk("len_cnt",    {24'd0, o_frame_cnt}, 32'd3);

        // Reset after bit 5 with ss held low; remaining bits must be ignored.
        v0 = n_valid; e0 = n_err;
        ss  = 1'b0;
        cap = '0;
        for (int i = 15; i >= 11; i--) clock_bit(1'b0);
        do_reset();
        for (int i = 10; i >= 0; i--) clock_bit(1'b1);
        repeat (2) @(negedge clk);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_errs",   n_err - e0, 32'd0);
        chk("abort_valids", n_valid - v0, 32'd0);
        send_frame(32'h0100, 16, mb);
        chk("fresh_counter", {18'd0, o_counter}, 32'd256);
        chk("fresh_cnt",     {24'd0, o_frame_cnt}, 32'd1);

        do_reset();
        for (int k = 0; k < 256; k++) begin
            send_frame(32'((k * 37 + 5) & 14'h3FFF), 16, mb);
            if (k == 254) chk("wrap_255", {24'd0, o_frame_cnt}, 32'd255);
        end
        chk("wrap_0",   {24'd0, o_frame_cnt}, 32'd0);
        chk("wrap_val", {18'd0, o_counter}, 32'((255 * 37 + 5) & 14'h3FFF));
        chk("pend_empty", pend.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
